// File: rtl/cnn_pkg.sv
// Shared CNN definitions: image/kernel defaults and the window scheduler state encoding.
package cnn_pkg;

  localparam int unsigned IMG_W_DEFAULT = 28;
  localparam int unsigned IMG_H_DEFAULT = 28;
  localparam int unsigned K_DEFAULT     = 3;
  localparam int unsigned TAPS          = K_DEFAULT * K_DEFAULT;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } sched_state_e;

endpackage

// File: rtl/conv_tap_counter.sv
// Kernel-tap counter: walks kc then kr across a KxK window and flags the first/last tap.
module conv_tap_counter
  import cnn_pkg::*;
#(
  parameter int unsigned K = K_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active_i,
  input  logic       step_i,
  input  logic       clr_i,
  output logic [3:0] tap_idx_o,
  output logic       kc_wrap_o,
  output logic       tap_wrap_o,
  output logic       first_tap_o,
  output logic       last_tap_o
);

  localparam logic [3:0] KMax   = 4'(K - 1);
  localparam logic [3:0] TapMax = 4'(K * K - 1);

  logic [3:0] kc_q, kc_d;
  logic [3:0] kr_q, kr_d;
  logic [3:0] tap_q, tap_d;

  assign kc_wrap_o  = (kc_q == KMax);
  assign tap_wrap_o = (tap_q == TapMax);

  always_comb begin
    kc_d  = kc_q;
    kr_d  = kr_q;
    tap_d = tap_q;
    if (clr_i) begin
      kc_d  = '0;
      kr_d  = '0;
      tap_d = '0;
    end else if (step_i) begin
      if (kc_wrap_o) begin
        kc_d = '0;
        kr_d = (kr_q == KMax) ? 4'd0 : kr_q + 4'd1;
      end else begin
        kc_d = kc_q + 4'd1;
      end
      tap_d = tap_wrap_o ? 4'd0 : tap_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kc_q  <= '0;
      kr_q  <= '0;
      tap_q <= '0;
    end else begin
      kc_q  <= kc_d;
      kr_q  <= kr_d;
      tap_q <= tap_d;
    end
  end

  // Qualifiers only mean something while a scan is presenting taps.
  assign tap_idx_o   = tap_q;
  assign first_tap_o = active_i && (tap_q == 4'd0);
  assign last_tap_o  = active_i && tap_wrap_o;

endmodule

// File: rtl/conv_window_scheduler.sv
// Sliding-window read scheduler: emits one pixel address per kernel tap for every output pixel.
module conv_window_scheduler
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = IMG_W_DEFAULT,
  parameter int unsigned IMG_H  = IMG_H_DEFAULT,
  parameter int unsigned K      = K_DEFAULT,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        tap_idx,
  output logic              first_tap,
  output logic              last_tap,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] WStep  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(IMG_W - K);
  localparam logic [ADDR_W-1:0] RowMax = ADDR_W'(IMG_H - K);

  sched_state_e state_q, state_d;

  logic [ADDR_W-1:0] out_row_q, out_row_d;
  logic [ADDR_W-1:0] out_col_q, out_col_d;
  logic [ADDR_W-1:0] row_start_q, row_start_d;  // out_row * IMG_W
  logic [ADDR_W-1:0] win_base_q, win_base_d;    // window origin address
  logic [ADDR_W-1:0] row_base_q, row_base_d;    // address of tap (kr, 0)
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic in_run, xfer, last_xfer, clr, step;
  logic kc_wrap, tap_wrap;

  assign in_run    = (state_q == StRun);
  assign xfer      = in_run && rd_ready;
  assign last_xfer = xfer && tap_wrap && (out_col_q == ColMax) && (out_row_q == RowMax);
  // Abort and final transfer both leave RUN with every counter back at zero.
  assign clr       = in_run && (abort || last_xfer);
  assign step      = xfer && !clr;

  conv_tap_counter #(
    .K(K)
  ) u_tap_counter (
    .clk        (clk),
    .rst        (rst),
    .active_i   (in_run),
    .step_i     (step),
    .clr_i      (clr),
    .tap_idx_o  (tap_idx),
    .kc_wrap_o  (kc_wrap),
    .tap_wrap_o (tap_wrap),
    .first_tap_o(first_tap),
    .last_tap_o (last_tap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else if (last_xfer) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy     = (state_q == StRun);
    rd_valid = (state_q == StRun);
    done     = (state_q == StDone);
  end

  always_comb begin
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    row_start_d = row_start_q;
    win_base_d  = win_base_q;
    row_base_d  = row_base_q;
    rd_addr_d   = rd_addr_q;
    if (clr) begin
      out_row_d   = '0;
      out_col_d   = '0;
      row_start_d = '0;
      win_base_d  = '0;
      row_base_d  = '0;
      rd_addr_d   = '0;
    end else if (step) begin
      if (!kc_wrap) begin
        rd_addr_d = rd_addr_q + 1'b1;
      end else if (!tap_wrap) begin
        row_base_d = row_base_q + WStep;
        rd_addr_d  = row_base_d;
      end else if (out_col_q != ColMax) begin
        out_col_d  = out_col_q + 1'b1;
        win_base_d = win_base_q + 1'b1;
        row_base_d = win_base_d;
        rd_addr_d  = win_base_d;
      end else begin
        out_col_d   = '0;
        out_row_d   = out_row_q + 1'b1;
        row_start_d = row_start_q + WStep;
        win_base_d  = row_start_d;
        row_base_d  = row_start_d;
        rd_addr_d   = row_start_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_row_q   <= '0;
      out_col_q   <= '0;
      row_start_q <= '0;
      win_base_q  <= '0;
      row_base_q  <= '0;
      rd_addr_q   <= '0;
    end else begin
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      row_start_q <= row_start_d;
      win_base_q  <= win_base_d;
      row_base_q  <= row_base_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign out_row = out_row_q;
  assign out_col = out_col_q;

endmodule
